beeper_seq_arb: RTL



---
 rtl/beeper_pkg.sv | 29 ++
 rtl/beeper_seq_arb_if.sv | 39 +++
 rtl/beeper_prio_enc.sv | 29 ++
 rtl/beeper_seq_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/beeper_pkg.sv
// Shared types for the beeper datapath: beeper operating modes and the
// state encoding of the alarm sequencer/arbiter that drives the beeper.
package beeper_pkg;

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    ON         = 3'd1,
    TIME       = 3'd2,
    FORCE_ZERO = 3'd3,
    FORCE_ONE  = 3'd4
  } beeper_mode_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_LOAD  = 3'd1,
    SEQ_START = 3'd2,
    SEQ_BEEP  = 3'd3,
    SEQ_GAP   = 3'd4,
    SEQ_DONE  = 3'd5
  } beeper_seq_state_t;

  localparam int unsigned TICK_W = 32;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beeper_seq_arb_if.sv
// Bundle between the alarm sources, the sequencer/arbiter and the beeper core.
//   req_i/phase_i/on_ticks_i/off_ticks_i/repeat_i : per-source pattern requests
//   grant_o/done_o/abort_o/busy_o                 : arbitration status
//   mode_o/osc_phase_o/osc_phase_wr_stb_o/
//   gen_time_o/timer_run_stb_o                    : beeper core controls
// slave is the sequencer side, master the requester/observer side.
interface beeper_seq_arb_if
  import beeper_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int CNT_W   = 8
);
  logic [REQ_CNT-1:0]              req_i;
  logic [REQ_CNT-1:0][TICK_W-1:0]  phase_i;
  logic [REQ_CNT-1:0][TICK_W-1:0]  on_ticks_i;
  logic [REQ_CNT-1:0][TICK_W-1:0]  off_ticks_i;
  logic [REQ_CNT-1:0][CNT_W-1:0]   repeat_i;
  logic [REQ_CNT-1:0]              grant_o;
  logic [REQ_CNT-1:0]              done_o;
  logic [REQ_CNT-1:0]              abort_o;
  logic                            busy_o;
  beeper_mode_t                    mode_o;
  logic [TICK_W-1:0]               osc_phase_o;
  logic                            osc_phase_wr_stb_o;
  logic [TICK_W-1:0]               gen_time_o;
  logic                            timer_run_stb_o;

  modport slave (
    input  req_i, phase_i, on_ticks_i, off_ticks_i, repeat_i,
    output grant_o, done_o, abort_o, busy_o, mode_o,
           osc_phase_o, osc_phase_wr_stb_o, gen_time_o, timer_run_stb_o
  );

  modport master (
    output req_i, phase_i, on_ticks_i, off_ticks_i, repeat_i,
    input  grant_o, done_o, abort_o, busy_o, mode_o,
           osc_phase_o, osc_phase_wr_stb_o, gen_time_o, timer_run_stb_o
  );
endinterface

// File: rtl/beeper_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins.
//   req    : request vector
//   onehot : one-hot winner (zero when no request)
//   idx    : binary index of the winner
//   any    : at least one request present
module beeper_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  // Scanning downwards lets the lowest index overwrite higher ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/beeper_seq_arb.sv
// Sequencer and fixed-priority, non-preemptive arbiter sharing one beeper
// among REQ_CNT alarm sources. Each granted source gets: phase load, then
// repeat x (TIME-mode beep of on_ticks, OFF gap of off_ticks), then done.
//   clk_i  : system clock
//   srst_i : synchronous active-high reset
//   bus    : request/status/beeper-control bundle (slave side)
module beeper_seq_arb
  import beeper_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  beeper_seq_arb_if.slave   bus
);
  localparam int IDX_W = int'(idx_w(REQ_CNT));

  beeper_seq_state_t   state;
  logic [REQ_CNT-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [TICK_W-1:0]   on_lat;
  logic [TICK_W-1:0]   off_lat;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]    rem_cnt;
  logic                req_lost;

  function automatic logic [TICK_W-1:0] sat_tick(input logic [TICK_W-1:0] v);
    return (v == '0) ? TICK_W'(1) : v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  beeper_prio_enc #(.N(REQ_CNT), .IDX_W(IDX_W)) u_prio (
    .req    (bus.req_i),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // The served source has released its request line.
  assign req_lost = ((bus.req_i & bus.grant_o) == '0);

  // Pattern timing captured at grant; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (state == SEQ_IDLE && win_any) begin
      on_lat  <= sat_tick(bus.on_ticks_i[win_idx]);
      off_lat <= sat_tick(bus.off_ticks_i[win_idx]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state                  <= SEQ_IDLE;
      bus.grant_o            <= '0;
      bus.done_o             <= '0;
      bus.abort_o            <= '0;
      bus.busy_o             <= 1'b0;
      bus.mode_o             <= OFF;
      bus.osc_phase_o        <= '0;
      bus.osc_phase_wr_stb_o <= 1'b0;
      bus.gen_time_o         <= '0;
      bus.timer_run_stb_o    <= 1'b0;
      tick_cnt               <= '0;
      rem_cnt                <= '0;
    end else begin
      bus.done_o             <= '0;
      bus.abort_o            <= '0;
      bus.osc_phase_wr_stb_o <= 1'b0;
      bus.timer_run_stb_o    <= 1'b0;
      // Abort wins over every other transition, including the one into DONE.
      // Grant stays up through the abort cycle and is dropped from IDLE.
      if (state != SEQ_IDLE && state != SEQ_DONE && req_lost) begin
        state       <= SEQ_IDLE;
        bus.mode_o  <= OFF;
        bus.abort_o <= bus.grant_o;
        bus.busy_o  <= 1'b0;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (win_any) begin
              state                  <= SEQ_LOAD;
              bus.grant_o            <= win_oh;
              bus.busy_o             <= 1'b1;
              bus.osc_phase_o        <= bus.phase_i[win_idx];
              bus.osc_phase_wr_stb_o <= 1'b1;
              rem_cnt                <= sat_cnt(bus.repeat_i[win_idx]);
            end else begin
              bus.grant_o <= '0;
            end
          end
          SEQ_LOAD: begin
            state               <= SEQ_START;
            bus.mode_o          <= TIME;
            bus.gen_time_o      <= on_lat;
            bus.timer_run_stb_o <= 1'b1;
          end
          SEQ_START: begin
            state    <= SEQ_BEEP;
            tick_cnt <= on_lat;
          end
          SEQ_BEEP: begin
            if (tick_cnt <= TICK_W'(1)) begin
              state      <= SEQ_GAP;
              bus.mode_o <= OFF;
              tick_cnt   <= off_lat;
            end else begin
              tick_cnt <= tick_cnt - TICK_W'(1);
            end
          end
          SEQ_GAP: begin
            if (tick_cnt <= TICK_W'(1)) begin
              if (rem_cnt > CNT_W'(1)) begin
                rem_cnt             <= rem_cnt - CNT_W'(1);
                state               <= SEQ_START;
                bus.mode_o          <= TIME;
                bus.gen_time_o      <= on_lat;
                bus.timer_run_stb_o <= 1'b1;
              end else begin
                state      <= SEQ_DONE;
                bus.done_o <= bus.grant_o;
              end
            end else begin
              tick_cnt <= tick_cnt - TICK_W'(1);
            end
          end
          SEQ_DONE: begin
            state       <= SEQ_IDLE;
            bus.busy_o  <= 1'b0;
            bus.grant_o <= '0;
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end
endmodule
